// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch/execute sequencer: FSM states, opcodes,
// accumulator source selects and the post-reset instruction register value.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_IMM = 2'd0,
    SEL_INC = 2'd1,
    SEL_ADD = 2'd2,
    SEL_LDR = 2'd3
  } asel_t;

  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_LDR = 4'hA;
  localparam logic [3:0] OP_STR = 4'hB;
  localparam logic [3:0] OP_NOP = 4'hC;
  localparam logic [3:0] OP_LDI = 4'hD;
  localparam logic [3:0] OP_RST = 4'hE;

  localparam logic [7:0] IR_RESET = 8'hC0;

endpackage

// File: rtl/cpu_if.sv
// Control/ROM/datapath signal bundle around the sequencer.
// master = sequencer side, slave = environment (ROM, datapath, operator).
interface cpu_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
);
  logic                  RUN;
  logic                  STEP;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [WIDTH-1:0]      DATA;
  logic                  A_WE;
  logic [1:0]            A_SEL;
  logic                  R_WE;
  logic [3:0]            IMM;
  logic                  BUSY;
  logic                  ILLEGAL;
  logic                  ERR;
  logic [CNT_WIDTH-1:0]  RETIRED;

  modport master (
    input  RUN, STEP, DATA,
    output ADDR, A_WE, A_SEL, R_WE, IMM, BUSY, ILLEGAL, ERR, RETIRED
  );

  modport slave (
    output RUN, STEP, DATA,
    input  ADDR, A_WE, A_SEL, R_WE, IMM, BUSY, ILLEGAL, ERR, RETIRED
  );
endinterface

// File: rtl/cpu_decode.sv
// Combinational opcode decode: datapath strobes and selects are only
// produced while the exec bit is set, otherwise everything idles at 0.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic       exec,
  output logic       a_we,
  output logic [1:0] a_sel,
  output logic       r_we,
  output logic       illegal
);

  always_comb begin
    a_we    = 1'b0;
    a_sel   = '0;
    r_we    = 1'b0;
    illegal = 1'b0;
    if (exec) begin
      case (op)
        OP_ADD: begin a_we = 1'b1; a_sel = SEL_ADD; end
        OP_INC: begin a_we = 1'b1; a_sel = SEL_INC; end
        OP_LDR: begin a_we = 1'b1; a_sel = SEL_LDR; end
        OP_STR: r_we = 1'b1;
        OP_NOP: ;
        OP_LDI: begin a_we = 1'b1; a_sel = SEL_IMM; end
        OP_RST: ;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Fetch/execute sequencer: owns PC, IR, the step flag, the sticky error flag
// and the retired-instruction counter; opcode decode lives in cpu_decode.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input logic      CLK,
  input logic      RST,
  cpu_if.master    bus
);

  state_t                state, state_nxt;
  logic                  step_flag, step_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [WIDTH-1:0]      ir;
  logic                  err;
  logic [CNT_WIDTH-1:0]  retired;
  logic [3:0]            op;
  logic                  illegal;

  assign op = ir[WIDTH-1 -: 4];

  cpu_decode u_decode (
    .op      (op),
    .exec    (state == EXEC),
    .a_we    (bus.A_WE),
    .a_sel   (bus.A_SEL),
    .r_we    (bus.R_WE),
    .illegal (illegal)
  );

  always_comb begin
    state_nxt = state;
    step_nxt  = step_flag;
    case (state)
      IDLE: begin
        if (bus.RUN) begin
          state_nxt = FETCH;
          step_nxt  = 1'b0;
        end else if (bus.STEP) begin
          state_nxt = FETCH;
          step_nxt  = 1'b1;
        end
      end
      FETCH: state_nxt = EXEC;
      // A single-stepped instruction always parks in IDLE, even with RUN high.
      EXEC: begin
        state_nxt = (bus.RUN && !step_flag) ? FETCH : IDLE;
        step_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      step_flag <= 1'b0;
      pc        <= '0;
      ir        <= IR_RESET;
      err       <= 1'b0;
      retired   <= '0;
    end else begin
      state     <= state_nxt;
      step_flag <= step_nxt;
      if (state == FETCH) ir <= bus.DATA;
      if (state == EXEC) begin
        pc      <= (op == OP_RST) ? '0 : pc + ADDR_WIDTH'(1);
        retired <= retired + CNT_WIDTH'(1);
        if (illegal) err <= 1'b1;
      end
    end
  end

  assign bus.ADDR    = pc;
  assign bus.IMM     = ir[3:0];
  assign bus.BUSY    = (state != IDLE);
  assign bus.ILLEGAL = illegal;
  assign bus.ERR     = err;
  assign bus.RETIRED = retired;

endmodule
